// File: rtl/camera_wr_queue.sv
// Per-channel write FIFOs feeding a round-robin arbiter that issues single-cycle
// write requests to the RAM controller in the 133 MHz domain.

module camera_wr_queue_fifo #(
    parameter int EW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_133M,
    input  logic                   rst,
    input  logic                   push,
    input  logic [EW-1:0]          push_entry,
    input  logic                   pop,
    output logic [EW-1:0]          head,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_ok;

    // A full FIFO refuses the beat even if it is popped on the same edge.
    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_133M) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk_133M or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end
endmodule

module camera_wr_queue #(
    parameter int N_CH   = 3,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 25,
    parameter int DEPTH  = 16,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                   clk_133M,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH*ADDR_W-1:0] in_address,
    input  logic [N_CH*2-1:0]      in_change_frame,
    input  logic [N_CH-1:0]        in_frame_done,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   ram_busy,
    output logic [DATA_W-1:0]      o_p_data,
    output logic [ADDR_W-1:0]      o_wr_address,
    output logic [1:0]             o_change_frame,
    output logic                   o_frame_done,
    output logic [CH_W-1:0]        o_channel,
    output logic                   wr_req,
    output logic [N_CH-1:0]        ovf,
    input  logic                   ovf_clr,
    output logic [N_CH*LW-1:0]     level
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        cf;
        logic              fd;
    } beat_t;

    beat_t             head_q [N_CH];
    logic [LW-1:0]     cnt    [N_CH];
    logic [N_CH-1:0]   full, nonempty, pop;
    logic [CH_W-1:0]   last_grant, win_ch;
    logic              issue;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        beat_t in_beat;
        assign in_beat = '{data: in_data[i*DATA_W +: DATA_W],
                           addr: in_address[i*ADDR_W +: ADDR_W],
                           cf:   in_change_frame[2*i +: 2],
                           fd:   in_frame_done[i]};

        camera_wr_queue_fifo #(.EW($bits(beat_t)), .DEPTH(DEPTH)) u_fifo (
            .clk_133M   (clk_133M),
            .rst        (rst),
            .push       (in_valid[i]),
            .push_entry (in_beat),
            .pop        (pop[i]),
            .head       (head_q[i]),
            .full       (full[i]),
            .count      (cnt[i])
        );

        assign in_ready[i]        = !full[i];
        assign nonempty[i]        = (cnt[i] != '0);
        assign level[i*LW +: LW]  = cnt[i];
        assign pop[i]             = issue && (win_ch == CH_W'(i));
    end

    // Scan downward so the nearest non-empty channel after last_grant wins.
    always_comb begin
        win_ch = last_grant;
        for (int k = N_CH; k >= 1; k--) begin
            if (nonempty[(int'(last_grant) + k) % N_CH])
                win_ch = CH_W'((int'(last_grant) + k) % N_CH);
        end
    end

    // The idle cycle after every request lets the controller raise ram_busy.
    assign issue = !ram_busy && !wr_req && (|nonempty);

    always_ff @(posedge clk_133M or posedge rst) begin
        if (rst) begin
            o_p_data       <= '0;
            o_wr_address   <= '0;
            o_change_frame <= '0;
            o_frame_done   <= 1'b0;
            o_channel      <= '0;
            wr_req         <= 1'b0;
            last_grant     <= CH_W'(N_CH - 1);
            ovf            <= '0;
        end else begin
            wr_req <= issue;
            if (issue) begin
                o_p_data       <= head_q[win_ch].data;
                o_wr_address   <= head_q[win_ch].addr;
                o_change_frame <= head_q[win_ch].cf;
                o_frame_done   <= head_q[win_ch].fd;
                o_channel      <= win_ch;
                last_grant     <= win_ch;
            end
            ovf <= (ovf & ~{N_CH{ovf_clr}}) | (in_valid & full);
        end
    end
endmodule

// File: tb/tb_camera_wr_queue.sv
// Bench for camera_wr_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a long randomized run.

module tb_camera_wr_queue;
    localparam int N = 3, DW = 128, AWD = 25, DEPTH = 16, LW = 5;

    logic              clk_133M = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   in_data;
    logic [N*AWD-1:0]  in_address;
    logic [N*2-1:0]    in_change_frame;
    logic [N-1:0]      in_frame_done, in_valid, in_ready, ovf;
    logic              ram_busy, ovf_clr;
    logic [DW-1:0]     o_p_data;
    logic [AWD-1:0]    o_wr_address;
    logic [1:0]        o_change_frame, o_channel;
    logic              o_frame_done, wr_req;
    logic [N*LW-1:0]   level;

    always #5 clk_133M = ~clk_133M;

    camera_wr_queue #(.N_CH(N), .DATA_W(DW), .ADDR_W(AWD), .DEPTH(DEPTH)) dut (
        .clk_133M(clk_133M), .rst(rst), .in_data(in_data), .in_address(in_address),
        .in_change_frame(in_change_frame), .in_frame_done(in_frame_done),
        .in_valid(in_valid), .in_ready(in_ready), .ram_busy(ram_busy),
        .o_p_data(o_p_data), .o_wr_address(o_wr_address), .o_change_frame(o_change_frame),
        .o_frame_done(o_frame_done), .o_channel(o_channel), .wr_req(wr_req),
        .ovf(ovf), .ovf_clr(ovf_clr), .level(level)
    );

    typedef struct {
        logic [DW-1:0]  d;
        logic [AWD-1:0] a;
        logic [1:0]     cf;
        logic           fd;
    } beat_t;

    beat_t          q [N][$];
    logic           m_wr;
    beat_t          m_out;
    logic [1:0]     m_ch;
    int             m_last;
    logic [N-1:0]   m_ovf;
    int             n_vec = 0, n_err = 0;
    bit             chk_en = 0;
    logic [1:0]     g_ch [$];
    logic [AWD-1:0] g_a  [$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t beat_of(int c);
        beat_t b;
        b.d  = in_data[c*DW +: DW];
        b.a  = in_address[c*AWD +: AWD];
        b.cf = in_change_frame[2*c +: 2];
        b.fd = in_frame_done[c];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        m_wr = 0; m_out.d = '0; m_out.a = '0; m_out.cf = '0; m_out.fd = 0;
        m_ch = '0; m_last = N - 1; m_ovf = '0;
    endtask

    // One clock edge of the intended behaviour, using pre-edge occupancy.
    task automatic model_step();
        int sz [N];
        int win;
        if (rst) return;
        for (int i = 0; i < N; i++) sz[i] = q[i].size();
        win = -1;
        if (!ram_busy && !m_wr)
            for (int k = 1; k <= N; k++)
                if (win < 0 && sz[(m_last + k) % N] > 0) win = (m_last + k) % N;
        m_wr = (win >= 0);
        if (win >= 0) begin
            m_out  = q[win].pop_front();
            m_ch   = 2'(win);
            m_last = win;
        end
        if (ovf_clr) m_ovf = '0;
        for (int i = 0; i < N; i++)
            if (in_valid[i]) begin
                if (sz[i] < DEPTH) q[i].push_back(beat_of(i));
                else m_ovf[i] = 1'b1;
            end
    endtask

    always @(negedge clk_133M) begin
        if (chk_en) begin
            chk("wr_req", 256'(wr_req), 256'(m_wr));
            chk("o_p_data", 256'(o_p_data), 256'(m_out.d));
            chk("o_wr_address", 256'(o_wr_address), 256'(m_out.a));
            chk("o_change_frame", 256'(o_change_frame), 256'(m_out.cf));
            chk("o_frame_done", 256'(o_frame_done), 256'(m_out.fd));
            chk("o_channel", 256'(o_channel), 256'(m_ch));
            chk("ovf", 256'(ovf), 256'(m_ovf));
            for (int i = 0; i < N; i++) begin
                chk("level", 256'(level[i*LW +: LW]), 256'(q[i].size()));
                chk("in_ready", 256'(in_ready[i]), 256'(q[i].size() != DEPTH));
            end
        end
    end

    task automatic tick();
        @(posedge clk_133M);
        model_step();
        #1;
        if (wr_req) begin
            g_ch.push_back(o_channel);
            g_a.push_back(o_wr_address);
        end
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        ovf_clr  = 1'b0;
    endtask

    task automatic set_beat(int c, logic [DW-1:0] d, logic [AWD-1:0] a, logic [1:0] cf, logic fd);
        in_data[c*DW +: DW]       = d;
        in_address[c*AWD +: AWD]  = a;
        in_change_frame[2*c +: 2] = cf;
        in_frame_done[c]          = fd;
        in_valid[c]               = 1'b1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called just after an edge: pulse rst inside the cycle.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic clear_log();
        g_ch.delete();
        g_a.delete();
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_address = '0; in_change_frame = '0;
        in_frame_done = '0; ram_busy = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        chk("reset wr_req", 256'(wr_req), 256'(0));
        chk("reset level", 256'(level), 256'(0));
        chk("reset o_p_data", 256'(o_p_data), 256'(0));
        #9;
        rst = 1'b0;
        chk_en = 1;
        tick();

        // single beat latency and hold
        set_beat(0, {16{8'hA5}}, 25'h10, 2'd0, 1'b1);
        tick();
        idle_inputs();
        chk("lat push-edge wr_req", 256'(wr_req), 256'(0));
        chk("lat level0", 256'(level[0 +: LW]), 256'(1));
        tick();
        chk("lat wr_req", 256'(wr_req), 256'(1));
        chk("lat o_channel", 256'(o_channel), 256'(0));
        chk("lat addr", 256'(o_wr_address), 256'(25'h10));
        chk("lat data", 256'(o_p_data), 256'({16{8'hA5}}));
        chk("lat fd", 256'(o_frame_done), 256'(1));
        tick();
        chk("hold wr_req", 256'(wr_req), 256'(0));
        chk("hold addr", 256'(o_wr_address), 256'(25'h10));

        // three channels x four beats, round-robin
        do_reset();
        tick();
        clear_log();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < N; c++) set_beat(c, rnd_data(), 25'(c*256 + k), 2'(k), 1'b0);
            tick();
        end
        idle_inputs();
        repeat (30) tick();
        chk("rr count", 256'(g_ch.size()), 256'(12));
        if (g_ch.size() == 12)
            for (int j = 0; j < 12; j++) begin
                chk("rr channel", 256'(g_ch[j]), 256'(j % 3));
                chk("rr addr", 256'(g_a[j]), 256'((j % 3)*256 + j/3));
            end

        // fill ch1 while busy, then drain
        do_reset();
        tick();
        ram_busy = 1'b1;
        for (int k = 0; k < 18; k++) begin
            set_beat(1, rnd_data(), 25'(32'h200 + k), 2'd1, 1'b0);
            tick();
            if (k == 15) begin
                chk("full level1", 256'(level[LW +: LW]), 256'(16));
                chk("full in_ready1", 256'(in_ready[1]), 256'(0));
                chk("full ovf1 pre", 256'(ovf[1]), 256'(0));
            end
            if (k == 16) chk("ovf1 set", 256'(ovf[1]), 256'(1));
        end
        idle_inputs();
        ram_busy = 1'b0;
        clear_log();
        repeat (40) tick();
        chk("drain count", 256'(g_a.size()), 256'(16));
        if (g_a.size() == 16) chk("drain last addr", 256'(g_a[15]), 256'(25'h20F));

        // set beats clear on ch2
        do_reset();
        tick();
        ram_busy = 1'b1;
        for (int k = 0; k < 17; k++) begin
            set_beat(2, rnd_data(), 25'(32'h300 + k), 2'd2, 1'b1);
            tick();
        end
        set_beat(2, rnd_data(), 25'h3FF, 2'd2, 1'b1);
        ovf_clr = 1'b1;
        tick();
        chk("ovf2 set wins", 256'(ovf[2]), 256'(1));
        in_valid = '0;
        tick();
        chk("ovf2 cleared", 256'(ovf[2]), 256'(0));
        idle_inputs();
        ram_busy = 1'b0;
        repeat (40) tick();

        // busy toggling every cycle
        do_reset();
        tick();
        ram_busy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_beat(0, rnd_data(), 25'(32'h400 + k), 2'd3, 1'b0);
            tick();
        end
        idle_inputs();
        clear_log();
        for (int k = 0; k < 20; k++) begin
            ram_busy = 1'(k % 2);
            tick();
        end
        ram_busy = 1'b0;
        chk("toggle pulses", 256'(g_a.size()), 256'(6));

        // async reset mid-burst
        do_reset();
        tick();
        ram_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_beat(0, rnd_data(), 25'(32'h500 + k), 2'd0, 1'b0);
            tick();
        end
        idle_inputs();
        chk("mid level0", 256'(level[0 +: LW]), 256'(5));
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid rst level", 256'(level), 256'(0));
        chk("mid rst wr_req", 256'(wr_req), 256'(0));
        chk("mid rst ovf", 256'(ovf), 256'(0));
        chk("mid rst addr", 256'(o_wr_address), 256'(0));
        #1;
        rst = 1'b0;
        ram_busy = 1'b0;
        clear_log();
        repeat (5) tick();
        chk("post rst no req", 256'(g_a.size()), 256'(0));
        set_beat(1, rnd_data(), 25'h611, 2'd0, 1'b0);
        set_beat(0, rnd_data(), 25'h600, 2'd0, 1'b0);
        tick();
        idle_inputs();
        tick();
        chk("post rst wr_req", 256'(wr_req), 256'(1));
        chk("post rst first ch", 256'(o_channel), 256'(0));

        // randomized traffic
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            for (int n = 0; n < 500; n++) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, 99) < 40)
                        set_beat(c, rnd_data(), 25'($urandom()), 2'($urandom()), 1'($urandom()));
                    else
                        in_valid[c] = 1'b0;
                end
                ram_busy = ($urandom_range(0, 99) < ((blk % 2) ? 80 : 20));
                ovf_clr  = ($urandom_range(0, 99) < 5);
                if ($urandom_range(0, 999) == 0) do_reset();
                tick();
            end
        end
        idle_inputs();
        ram_busy = 1'b0;
        repeat (60) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/camera_wr_queue.md
Name: camera_wr_queue

Overview:
- Parametrised successor to the single-stream camera store stage, in the 133 MHz RAM-controller domain.
- Accepts write beats from N_CH already-synchronised camera/exposure streams, one per HDR exposure.
- Buffers each stream in its own FIFO and arbitrates round-robin between them.
- Issues single-cycle write requests to the RAM controller, respecting ram_busy.

Parameters:
N_CH, 3, number of input channels (>=1)
DATA_W, 128, pixel data word width
ADDR_W, 25, RAM word address width
DEPTH, 16, entries per channel FIFO (power of 2, >=2)

Ports:
clk_133M  in  1  RAM-domain clock; the only clock
rst  in  1  asynchronous, active-high reset
in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_address  in  N_CH*ADDR_W  channel i occupies bits [i*ADDR_W +: ADDR_W]
in_change_frame  in  N_CH*2  2 bits per channel
in_frame_done  in  N_CH  per-channel end-of-frame flag
in_valid  in  N_CH  per-channel beat valid
in_ready  out  N_CH  per-channel space available
ram_busy  in  1  RAM controller cannot take a request
o_p_data  out  DATA_W  granted data
o_wr_address  out  ADDR_W  granted address
o_change_frame  out  2  granted change_frame
o_frame_done  out  1  granted frame_done
o_channel  out  clog2(N_CH) (min 1)  index of granted channel
wr_req  out  1  one-cycle write strobe
ovf  out  N_CH  sticky per-channel overflow
ovf_clr  in  1  synchronous clear of all ovf bits
level  out  N_CH*(clog2(DEPTH)+1)  per-channel FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - All outputs 0: o_p_data, o_wr_address, o_change_frame, o_frame_done, o_channel, wr_req, ovf, level.
  - All FIFO counts and pointers cleared; stored entries are discarded.
  - Arbiter last-grant pointer = N_CH-1, so channel 0 wins first.
  - In-flight, un-issued beats are lost. A reset mid-operation is legal at any cycle.
- Push:
  - in_ready[i] = (count[i] != DEPTH), taken from the registered count.
  - A beat is stored on any edge where in_valid[i] && in_ready[i].
  - A full FIFO accepts no push, even in a cycle where it is also popped.
- Overflow:
  - in_valid[i] && !in_ready[i] sets ovf[i] on that edge; the beat is dropped.
  - ovf_clr clears all bits. If a set and a clear occur in the same cycle, the set wins.
- Issue decision at edge t:
  - Condition: ram_busy==0 && wr_req==0 && at least one count[i] != 0.
  - Winner is the first non-empty channel searching upward from last_grant+1, wrapping modulo N_CH.
  - The winner's head entry is popped; its fields and o_channel are registered; wr_req=1 for exactly that one cycle; last_grant = winner.
  - Otherwise wr_req=0.
- Request spacing: wr_req is never high two consecutive cycles. The low cycle after a request gives the RAM controller one cycle to raise ram_busy.
- Output hold: o_* fields change only on an issue edge and stay stable between requests.
- Latency: minimum 2 cycles from the accepting push edge to wr_req high (the push edge updates count; the next edge issues), provided ram_busy=0.
- Per-channel ordering is preserved.
- Fairness: with all channels continuously non-empty, grants cycle 0,1,...,N_CH-1,0,...
- Simultaneous push and pop on the same non-full channel: count unchanged, both take effect.
- Wrap-around: FIFO pointers wrap modulo DEPTH; level = count, ranging 0..DEPTH.
- ram_busy held high: no requests issue; FIFOs fill, in_ready drops, and further valid beats set ovf.
- N_CH=1: the arbiter degenerates to a single channel and o_channel is 0.

Test Plan:
- Single beat on ch0 (data=0xA5…A5, addr=0x0000010, frame_done=1), ram_busy=0 -> wr_req high exactly 2 cycles after the push edge, for 1 cycle; o_channel=0; fields match and then hold.
- All 3 channels each push 4 beats simultaneously, ram_busy=0 -> 12 wr_req pulses spaced every 2 cycles, o_channel sequence 0,1,2 repeated; per-channel addresses in push order.
- ram_busy=1 while ch1 pushes 18 beats -> level[1] reaches 16, in_ready[1]=0 after the 16th, ovf[1]=1 from the 17th; then ram_busy=0 -> exactly 16 requests issue, the 17th/18th beats are absent.
- ovf_clr asserted in the same cycle as a new overflow on ch2 -> ovf[2] stays 1; ovf_clr alone next cycle -> ovf[2]=0.
- ram_busy toggles 1/0 every cycle with ch0 non-empty -> wr_req only follows edges where ram_busy=0 and is never high on consecutive cycles.
- rst pulsed asynchronously mid-burst (level[0]=5) -> all outputs 0 immediately; after release no wr_req until new pushes; first grant goes to channel 0.
